// File: rtl/polifase2int.sv
// -----------------------------------------------------------------------------
// polifase2int -- 2:1 polyphase recombination (serializer).
//
// Accepts (x0, x1) sample pairs and emits them on y as x0 then x1, pairs in
// acceptance order. Samples pass through bit-exact.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   x0        in   WIDTH  even-phase sample (output position 2n)
//   x1        in   WIDTH  odd-phase sample  (output position 2n+1)
//   in_valid  in   pair on x0/x1 is valid
//   in_ready  out  block can accept a pair (depends on stored state only)
//   y         out  WIDTH  serialized output sample
//   y_valid   out  y holds a valid word
//   y_ready   in   downstream accepts y
//   y_phase   out  0 = y is the x0 word, 1 = y is the x1 word (phase state)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer never withdraws or changes data while valid=1 and
// ready=0; in_ready/y_valid never depend combinationally on the other side.
// -----------------------------------------------------------------------------
module polifase2int #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] x1,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             y_phase
);

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } phase_e;

   // Two-entry pair FIFO, stored as two parallel word arrays.
   logic [WIDTH-1:0] mem_x0_q [2];
   logic [WIDTH-1:0] mem_x0_d [2];
   logic [WIDTH-1:0] mem_x1_q [2];
   logic [WIDTH-1:0] mem_x1_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   phase_e           phase_q, phase_d;

   logic push;
   logic xfer;
   logic pop;

   // Outputs come straight from stored state, so no input-to-output paths.
   always_comb begin
      in_ready = (count_q != 2'd2);
      y_valid  = (count_q != 2'd0);
      y_phase  = phase_q;
      y        = (phase_q == ODD) ? mem_x1_q[rd_ptr_q] : mem_x0_q[rd_ptr_q];
   end

   always_comb begin
      push = in_valid & in_ready;
      xfer = y_valid & y_ready;
      // The head pair retires only once its second word has gone out.
      pop  = xfer & (phase_q == ODD);
   end

   always_comb begin
      mem_x0_d = mem_x0_q;
      mem_x1_d = mem_x1_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      phase_d  = phase_q;

      if (push) begin
         mem_x0_d[wr_ptr_q] = x0;
         mem_x1_d[wr_ptr_q] = x1;
         wr_ptr_d           = ~wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      case (phase_q)
         EVEN:    if (xfer) phase_d = ODD;
         ODD:     if (xfer) phase_d = EVEN;
         default: phase_d = EVEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_x0_q[0] <= '0;
         mem_x0_q[1] <= '0;
         mem_x1_q[0] <= '0;
         mem_x1_q[1] <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         phase_q     <= EVEN;
      end else begin
         mem_x0_q <= mem_x0_d;
         mem_x1_q <= mem_x1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         phase_q  <= phase_d;
      end
   end

endmodule

// File: tb/tb_polifase2int.sv
// -----------------------------------------------------------------------------
// tb_polifase2int -- bench for polifase2int.
// Reference model: a queue of output words. Every accepted pair appends x0
// then x1; every output transfer removes the front word. From that queue:
//   y_valid  = queue not empty
//   y        = front word
//   y_phase  = 1 when an odd number of words remain (head pair half sent)
//   in_ready = fewer than two pairs held, i.e. at most 2 words queued
// -----------------------------------------------------------------------------
module tb_polifase2int;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] x0 = '0;
  logic [W-1:0] x1 = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready = 1'b0;
  logic         y_phase;

  polifase2int #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .x0       (x0),
    .x1       (x1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_phase  (y_phase)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit           after_reset = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model (outputs depend on state only).
  task automatic check_outputs();
    logic [W-1:0] e_rdy, e_vld;
    e_rdy = (exp_q.size() <= 2) ? W'(1) : W'(0);
    e_vld = (exp_q.size() > 0)  ? W'(1) : W'(0);
    chk("in_ready", W'(in_ready), e_rdy);
    chk("y_valid",  W'(y_valid),  e_vld);
    if (exp_q.size() > 0) begin
      chk("y",       y,            exp_q[0]);
      chk("y_phase", W'(y_phase),  W'(exp_q.size() % 2));
    end else if (after_reset) begin
      chk("y_rst",       y,           W'(0));
      chk("y_phase_rst", W'(y_phase), W'(0));
    end
  endtask

  // driver: one clock cycle with the given inputs
  task automatic cycle(input bit r, input bit v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit yr);
    bit pushed, popped;
    @(negedge clk);
    rst = r; in_valid = v; x0 = a; x1 = b; y_ready = yr;
    #1;
    check_outputs();
    pushed = v && (exp_q.size() <= 2);
    popped = yr && (exp_q.size() > 0);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      after_reset = 1'b1;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (pushed) begin
        exp_q.push_back(a);
        exp_q.push_back(b);
      end
      if (pushed || popped) after_reset = 1'b0;
    end
  endtask

  task automatic idle(input bit yr);
    cycle(1'b0, 1'b0, '0, '0, yr);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    // reset state
    do_reset();
    do_reset();
    idle(1'b0);

    // single pair, y_ready=1
    cycle(1'b0, 1'b1, 16'h0001, 16'h0002, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // back-to-back pairs with in_valid held, no gaps expected
    cycle(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1);
    cycle(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1);
    cycle(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1);
    cycle(1'b0, 1'b1, 16'h5555, 16'h6666, 1'b1);
    cycle(1'b0, 1'b1, 16'h5555, 16'h6666, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // stall output while offering three pairs
    cycle(1'b0, 1'b1, 16'hA001, 16'hA002, 1'b0);
    cycle(1'b0, 1'b1, 16'hB001, 16'hB002, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hC001, 16'hC002, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'hC001, 16'hC002, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // y_ready toggling mid-pair
    cycle(1'b0, 1'b1, 16'hD00D, 16'hF00F, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);

    // reset with one full pair held and phase ODD
    cycle(1'b0, 1'b1, 16'h0E01, 16'h0E02, 1'b0);
    cycle(1'b0, 1'b1, 16'h0F01, 16'h0F02, 1'b1);
    cycle(1'b1, 1'b1, 16'h7777, 16'h8888, 1'b1);
    idle(1'b0);
    cycle(1'b0, 1'b1, 16'hABCD, 16'h1234, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // push together with the final x1 pop at count=1
    cycle(1'b0, 1'b1, 16'h1357, 16'h2468, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b1, 16'h9ABC, 16'hDEF0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // overall time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
